// File: rtl/ad7476_pkg.sv
// Shared definitions for the AD7476 serial ADC interface: FSM state
// encodings, default timing parameters and frame layout helpers.
package ad7476_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    SHIFT    = 2'd2,
    QUIET    = 2'd3
  } xfer_state_t;

  // SCLK half-period in clk_i cycles (legal 2..255)
  localparam int CLK_DIV_DEF   = 4;
  // CS_n-high quiet cycles after each frame (legal 1..255)
  localparam int QUIET_CYC_DEF = 8;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;

  // The AD7476 shifts out four leading zeros ahead of the 12-bit result;
  // any 1 among them means the frame was misaligned or the part misbehaved.
  function automatic logic lead_bits_set(input logic [FRAME_BITS-1:0] frame);
    return |frame[FRAME_BITS-1:DATA_BITS];
  endfunction

endpackage

// File: rtl/ad7476_sclk_div.sv
// Half-period tick generator and SCLK phase flop for the AD7476 frame.
// The counter only runs while en_i is high and restarts from zero each
// time it is enabled, so every frame begins with a full first half-period.
module ad7476_sclk_div
  import ad7476_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic tgl_i,
  output logic tick_o,
  output logic sclk_o
);

  localparam logic [7:0] HALF_TC = 8'(CLK_DIV - 1);

  logic [7:0] half_cnt_q;

  assign tick_o = en_i && (half_cnt_q == HALF_TC);

  // Half-period counter: 0..CLK_DIV-1, wraps to 0, held at 0 when disabled
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      half_cnt_q <= 8'd0;
    end else if (half_cnt_q == HALF_TC) begin
      half_cnt_q <= 8'd0;
    end else begin
      half_cnt_q <= half_cnt_q + 8'd1;
    end
  end

  // SCLK phase flop: idles high, flips at a half-period boundary on request
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      sclk_o <= 1'b1;
    end else if (tick_o && tgl_i) begin
      sclk_o <= ~sclk_o;
    end
  end

endmodule

// File: rtl/ad7476_spi_xfer.sv
// AD7476 conversion frame controller: drops CS_n, clocks 16 SCLK periods,
// captures the serial word, then holds CS_n high for a quiet interval
// before accepting the next start request.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | CS_n high, SCLK high, waiting for spi_start_i
// CS_SETUP | CS_n low, SCLK high for one half-period before clocking
// SHIFT    | 16 SCLK periods, data sampled at the end of each high phase
// QUIET    | CS_n high, result delivered in first cycle, done in last
module ad7476_spi_xfer
  import ad7476_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int QUIET_CYC = QUIET_CYC_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        spi_start_i,
  input  logic        spi_rden_i,
  output logic        spi_tfer_done_o,
  output logic        spi_busy_o,
  output logic        adc_cs_n_o,
  output logic        adc_sclk_o,
  input  logic        adc_sdata_i,
  output logic [11:0] adc_data_o,
  output logic        adc_data_wr_o,
  output logic        adc_lead_err_o
);

  localparam logic [7:0] QUIET_TC = 8'(QUIET_CYC - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  xfer_state_t state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  quiet_cnt_q, quiet_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        cs_n_q, cs_n_d;
  logic [11:0] data_q;
  logic        lead_q;

  logic        div_en;
  logic        div_tgl;
  logic        half_tick;
  logic        sclk;
  logic        wr;
  logic        done;

  assign div_en = (state_q == CS_SETUP) || (state_q == SHIFT);

  // The final high phase must not fall again: SCLK stays high into QUIET.
  assign div_tgl = (state_q == CS_SETUP) ||
                   ((state_q == SHIFT) && !(sclk && (bit_cnt_q == LAST_BIT)));

  ad7476_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (div_en),
    .tgl_i  (div_tgl),
    .tick_o (half_tick),
    .sclk_o (sclk)
  );

  // Next-state, counter and strobe decode
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    quiet_cnt_d = quiet_cnt_q;
    shift_d     = shift_q;
    cs_n_d      = cs_n_q;
    wr          = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (spi_start_i) begin
          state_d = CS_SETUP;
          cs_n_d  = 1'b0;
        end
      end

      CS_SETUP: begin
        if (half_tick) begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (half_tick && sclk) begin
          shift_d = {shift_q[14:0], adc_sdata_i};
          if (bit_cnt_q == LAST_BIT) begin
            state_d     = QUIET;
            bit_cnt_d   = 4'd0;
            cs_n_d      = 1'b1;
            quiet_cnt_d = QUIET_TC;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      QUIET: begin
        // quiet_cnt counts down from QUIET_TC; first cycle is the load value
        wr = (quiet_cnt_q == QUIET_TC) && spi_rden_i;
        if (quiet_cnt_q == 8'd0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          quiet_cnt_d = quiet_cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
      end
    endcase
  end

  // State, counters, shift register and CS_n flop
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      quiet_cnt_q <= 8'd0;
      shift_q     <= 16'd0;
      cs_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      shift_q     <= shift_d;
      cs_n_q      <= cs_n_d;
    end
  end

  // Result holding registers, refreshed on each delivered strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= 12'h000;
      lead_q <= 1'b0;
    end else if (wr) begin
      data_q <= shift_q[11:0];
      lead_q <= lead_bits_set(shift_q);
    end
  end

  // The strobe cycle presents the fresh word directly so a consumer can
  // latch adc_data_o while adc_data_wr_o is high; afterwards the register holds it.
  assign adc_data_o      = wr ? shift_q[11:0] : data_q;
  assign adc_lead_err_o  = wr ? lead_bits_set(shift_q) : lead_q;
  assign adc_data_wr_o   = wr;
  assign spi_tfer_done_o = done;
  assign spi_busy_o      = (state_q != IDLE);
  assign adc_cs_n_o      = cs_n_q;
  assign adc_sclk_o      = sclk;

endmodule

// File: tb/tb_ad7476_spi_xfer.sv
// Self-checking bench for ad7476_spi_xfer: a table of frames on a
// CLK_DIV=4/QUIET_CYC=8 instance and a back-to-back sequence on a
// CLK_DIV=2/QUIET_CYC=1 instance, each fed by a behavioural ADC model.
module tb_ad7476_spi_xfer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: default timing
  logic rst_a, start_a, rden_a, done_a, busy_a, cs_n_a, sclk_a, wr_a, lead_a;
  logic sdata_a = 1'b0;
  logic [11:0] data_a;
  logic [15:0] word_a = 16'h0000;
  int bit_a = 15;

  // instance B: fastest timing
  logic rst_b, start_b, rden_b, done_b, busy_b, cs_n_b, sclk_b, wr_b, lead_b;
  logic sdata_b = 1'b0;
  logic [11:0] data_b;
  logic [15:0] word_b = 16'h0000;
  int bit_b = 15;

  ad7476_spi_xfer #(.CLK_DIV(4), .QUIET_CYC(8)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .spi_start_i(start_a), .spi_rden_i(rden_a),
    .spi_tfer_done_o(done_a), .spi_busy_o(busy_a), .adc_cs_n_o(cs_n_a),
    .adc_sclk_o(sclk_a), .adc_sdata_i(sdata_a), .adc_data_o(data_a),
    .adc_data_wr_o(wr_a), .adc_lead_err_o(lead_a)
  );

  ad7476_spi_xfer #(.CLK_DIV(2), .QUIET_CYC(1)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .spi_start_i(start_b), .spi_rden_i(rden_b),
    .spi_tfer_done_o(done_b), .spi_busy_o(busy_b), .adc_cs_n_o(cs_n_b),
    .adc_sclk_o(sclk_b), .adc_sdata_i(sdata_b), .adc_data_o(data_b),
    .adc_data_wr_o(wr_b), .adc_lead_err_o(lead_b)
  );

  // ADC models: present word bit k (MSB first) during the k-th SCLK high phase
  always @(posedge sclk_a or posedge cs_n_a) begin
    if (cs_n_a) bit_a = 15;
    else if (bit_a >= 0) begin
      sdata_a = word_a[bit_a];
      bit_a = bit_a - 1;
    end
  end

  always @(posedge sclk_b or posedge cs_n_b) begin
    if (cs_n_b) bit_b = 15;
    else if (bit_b >= 0) begin
      sdata_b = word_b[bit_b];
      bit_b = bit_b - 1;
    end
  end

  typedef struct {
    logic [11:0] data;
    logic        lead;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  typedef struct {
    logic [15:0] word;
    logic        rden;
    int          ex1;       // extra start cycle, -1 for none
    int          ex2;
    int          rstc;      // reset cycle, -1 for none
    int          len;       // cycles observed after the start cycle
    logic [11:0] exp_data;  // adc_data_o after the frame
    logic        exp_wr;
  } vec_t;

  vec_t vecs[7];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [11:0] d, input logic l,
                           inout exp_t q[$]);
    exp_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_unexpected_wr: got data 0x%0h, expected no strobe", tag, d);
    end else begin
      e = q.pop_front();
      check({tag, "_data"}, int'(d), int'(e.data));
      check({tag, "_lead"}, int'(l), int'(e.lead));
    end
  endtask

  task automatic run_frame_a(input vec_t v, input int idx);
    int   cs_first = -1, cs_last = -1, rises = 0, first_rise = -1;
    int   wr_cnt = 0, wr_cyc = -1, done_cnt = 0, done_cyc = -1;
    logic prev_sclk;
    bit   aborted;
    exp_t e;
    string tag;
    tag = $sformatf("f%0d", idx);
    aborted = (v.rstc >= 0);
    word_a = v.word;
    rden_a = v.rden;
    if (v.rden && !aborted) begin
      e.data = v.word[11:0];
      e.lead = |v.word[15:12];
      sb_a.push_back(e);
    end
    @(negedge clk);
    start_a = 1'b1;
    prev_sclk = sclk_a;
    for (int r = 1; r <= v.len; r++) begin
      @(negedge clk);
      if (!cs_n_a) begin
        if (cs_first < 0) cs_first = r;
        cs_last = r;
      end
      if (sclk_a && !prev_sclk) begin
        rises++;
        if (first_rise < 0) first_rise = r;
      end
      prev_sclk = sclk_a;
      if (wr_a) begin
        wr_cnt++;
        wr_cyc = r;
        pop_check(tag, data_a, lead_a, sb_a);
      end
      if (done_a) begin
        done_cnt++;
        done_cyc = r;
      end
      if (aborted && r == v.rstc + 1) begin
        check({tag, "_abort_cs_n"}, int'(cs_n_a), 1);
        check({tag, "_abort_sclk"}, int'(sclk_a), 1);
        check({tag, "_abort_busy"}, int'(busy_a), 0);
      end
      start_a = (r == v.ex1) || (r == v.ex2);
      rst_a   = (r == v.rstc);
    end
    if (!aborted) begin
      check({tag, "_cs_first"}, cs_first, 1);
      check({tag, "_cs_last"}, cs_last, 132);
      check({tag, "_sclk_rises"}, rises, 16);
      check({tag, "_first_rise"}, first_rise, 9);
      check({tag, "_done_cyc"}, done_cyc, 140);
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_wr_cnt"}, wr_cnt, int'(v.exp_wr));
      if (v.exp_wr) check({tag, "_wr_cyc"}, wr_cyc, 133);
    end else begin
      check({tag, "_cs_first"}, cs_first, 1);
      check({tag, "_wr_cnt"}, wr_cnt, 0);
      check({tag, "_done_cnt"}, done_cnt, 0);
    end
    check({tag, "_data_after"}, int'(data_a), int'(v.exp_data));
  endtask

  initial begin
    logic [15:0] words_b[4];
    int   cs_fall[4];
    int   n_fall, n_done, k, t0;
    logic prev_cs, pending;
    exp_t e;

    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] words_b[4];
    int   cs_fall[4];
    int   n_fall, n_done, k, t0;
    logic prev_cs, pending;
    exp_t e;

    //         word      rden  ex1 ex2  rst  len  data     wr
    vecs[0] = '{16'h0ABC, 1'b1, -1, -1,  -1, 140, 12'hABC, 1'b1};
    vecs[1] = '{16'h8123, 1'b1, -1, -1,  -1, 140, 12'h123, 1'b1};
    vecs[2] = '{16'h0FFF, 1'b0, -1, -1,  -1, 140, 12'h123, 1'b0};
    vecs[3] = '{16'h0555, 1'b1, 50, 140, -1, 140, 12'h555, 1'b1};
    vecs[4] = '{16'h0AAA, 1'b1, -1, -1,  -1, 140, 12'hAAA, 1'b1};
    vecs[5] = '{16'h0F0F, 1'b1, -1, -1,  60,  61, 12'h000, 1'b0};
    vecs[6] = '{16'h0321, 1'b1, -1, -1,  -1, 140, 12'h321, 1'b1};

    words_b[0] = 16'h0123;
    words_b[1] = 16'h0FED;
    words_b[2] = 16'h9876;
    words_b[3] = 16'h0000;

    rst_a = 1'b1; start_a = 1'b0; rden_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; rden_b = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_a_cs_n", int'(cs_n_a), 1);
    check("rst_a_sclk", int'(sclk_a), 1);
    check("rst_a_busy", int'(busy_a), 0);
    check("rst_a_done", int'(done_a), 0);
    check("rst_a_wr", int'(wr_a), 0);
    check("rst_a_lead", int'(lead_a), 0);
    check("rst_a_data", int'(data_a), 0);
    check("rst_b_cs_n", int'(cs_n_b), 1);
    check("rst_b_sclk", int'(sclk_b), 1);
    check("rst_b_busy", int'(busy_b), 0);
    check("rst_b_data", int'(data_b), 0);

    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int i = 0; i < 7; i++) run_frame_a(vecs[i], i);
    start_a = 1'b0;
    check("sb_a_empty", sb_a.size(), 0);

    // back-to-back frames on instance B, each start in the cycle after done
    rden_b = 1'b1;
    word_b = words_b[0];
    e.data = words_b[0][11:0];
    e.lead = |words_b[0][15:12];
    sb_b.push_back(e);
    @(negedge clk);
    start_b = 1'b1;
    t0 = cyc;
    k = 1;
    n_fall = 0;
    n_done = 0;
    pending = 1'b0;
    prev_cs = cs_n_b;
    for (int r = 1; r <= 4 * 68 + 20 && n_done < 4; r++) begin
      @(negedge clk);
      start_b = pending;
      pending = 1'b0;
      if (!cs_n_b && prev_cs && n_fall < 4) begin
        cs_fall[n_fall] = cyc;
        n_fall++;
      end
      prev_cs = cs_n_b;
      if (wr_b) pop_check($sformatf("b2b%0d", k - 1), data_b, lead_b, sb_b);
      if (done_b) begin
        n_done++;
        if (k < 4) begin
          word_b = words_b[k];
          e.data = words_b[k][11:0];
          e.lead = |words_b[k][15:12];
          sb_b.push_back(e);
          pending = 1'b1;
          k++;
        end
      end
    end
    start_b = 1'b0;
    check("b2b_done_count", n_done, 4);
    check("b2b_cs_fall_count", n_fall, 4);
    if (n_fall == 4) begin
      check("b2b_first_cs_fall", cs_fall[0] - t0, 1);
      for (int i = 1; i < 4; i++)
        check($sformatf("b2b_period%0d", i), cs_fall[i] - cs_fall[i-1], 68);
    end
    check("sb_b_empty", sb_b.size(), 0);
    check("b2b_last_data", int'(data_b), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ad7476_spi_xfer.md
AD7476_SPI_XFER -- requirements
Module: ad7476_spi_xfer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving the SCLK half-period in clk_i cycles; legal values are 2..255.
REQ-002 The block SHALL have parameter QUIET_CYC, default 8, giving the number of CS_n-high quiet cycles after each frame; legal values are 1..255.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port rst_i, input, 1 bit: the reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port spi_start_i, input, 1 bit: a one-cycle request to run one conversion frame.
REQ-006 The block SHALL have port spi_rden_i, input, 1 bit: a level that enables delivery of the captured sample.
REQ-007 The block SHALL have port spi_tfer_done_o, output, 1 bit: a one-cycle pulse marking frame complete and the block ready.
REQ-008 The block SHALL have port spi_busy_o, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port adc_cs_n_o, output, 1 bit: the ADC chip select, active low.
REQ-010 The block SHALL have port adc_sclk_o, output, 1 bit: the ADC serial clock, idle high.
REQ-011 The block SHALL have port adc_sdata_i, input, 1 bit: the ADC serial data, MSB-first.
REQ-012 The block SHALL have port adc_data_o, output, 12 bits: the last captured conversion result.
REQ-013 The block SHALL have port adc_data_wr_o, output, 1 bit: a one-cycle write strobe for adc_data_o.
REQ-014 The block SHALL have port adc_lead_err_o, output, 1 bit: valid with adc_data_wr_o; high when any of the 4 leading bits was 1.

Function
REQ-015 The FSM SHALL have states IDLE, CS_SETUP, SHIFT and QUIET.
REQ-016 In IDLE, spi_start_i SHALL be sampled; when it is high, the next state is CS_SETUP and adc_cs_n_o goes low in the next cycle.
REQ-017 spi_start_i SHALL be ignored in every state except IDLE, with no queuing.
REQ-018 CS_SETUP SHALL last CLK_DIV cycles, with adc_sclk_o high; it then goes to SHIFT.
REQ-019 SHIFT SHALL generate exactly 16 SCLK periods, each with a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
REQ-020 adc_sdata_i SHALL be shifted into a 16-bit register in the last cycle of each high phase.
REQ-021 After the 16th high phase, the block SHALL drive adc_cs_n_o high and enter QUIET, with adc_sclk_o remaining high.
REQ-022 In the first QUIET cycle, if spi_rden_i is high, adc_data_o SHALL load shift[11:0], adc_lead_err_o SHALL equal |shift[15:12], and adc_data_wr_o SHALL pulse for one cycle.
REQ-023 In the first QUIET cycle, if spi_rden_i is low, adc_data_o SHALL hold its value and no strobe SHALL be issued.
REQ-024 QUIET SHALL last QUIET_CYC cycles; spi_tfer_done_o SHALL pulse in its last cycle, and the state SHALL return to IDLE in the next cycle.
REQ-025 Timing with start sampled in cycle 0: CS_n low from cycle 1; write strobe in cycle 1+33*CLK_DIV; done in cycle 33*CLK_DIV+QUIET_CYC; a new start is accepted from the following cycle.
REQ-026 The half-period counter SHALL be 8 bits and SHALL wrap from CLK_DIV-1 to 0; the bit counter SHALL be 4 bits and SHALL terminate at 15 with no wrap into a 17th period.
REQ-027 adc_cs_n_o and adc_sclk_o SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-028 While rst_i is high at a clk_i edge, the state SHALL be IDLE.
REQ-029 While rst_i is high at a clk_i edge, adc_cs_n_o=1, adc_sclk_o=1, spi_busy_o=0, spi_tfer_done_o=0, adc_data_wr_o=0, adc_lead_err_o=0, adc_data_o=12'h000, and all counters and the shift register SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame: CS_n goes high in the next cycle, and no strobe or done pulse is issued for the aborted frame.

Structure
REQ-031 State encodings and the default CLK_DIV and QUIET_CYC values SHALL live in the shared ad7476 definitions package, also used by the top-level FSM.
REQ-032 One sub-module, ad7476_sclk_div, SHALL provide the half-period tick counter and the SCLK phase flop; all other logic stays in ad7476_spi_xfer.

Verification
REQ-033 Scenario 1: with CLK_DIV=4 and QUIET_CYC=8, a start in cycle 0 with a model returning 16'h0ABC -> CS_n low in cycles 1..132, 16 SCLK periods, adc_data_o=12'hABC, wr in cycle 133, lead_err=0, done in cycle 140.
REQ-034 Scenario 2: model returns 16'h8123 -> adc_data_o=12'h123 with adc_lead_err_o=1 on the strobe.
REQ-035 Scenario 3: spi_rden_i low throughout, model returns 16'h0FFF -> no adc_data_wr_o, adc_data_o unchanged, done still pulses in cycle 140.
REQ-036 Scenario 4: extra start pulses in cycles 50 and 140 -> both ignored; only one frame runs; start in cycle 141 begins a second frame.
REQ-037 Scenario 5: rst_i high in cycle 60 -> CS_n=1 and SCLK=1 from cycle 61, no wr and no done pulse, and a start in cycle 62 runs a full clean frame.
REQ-038 Scenario 6: with CLK_DIV=2 and QUIET_CYC=1, back-to-back starts each issued in the cycle after done -> frame period of exactly 68 cycles, and data from consecutive model words is correct.
